// File: rtl/adc_responder_if.sv
// Controller <-> ADC handshake bundle: conversion request, chip-select read, and the
// converter's status/data outputs.
interface adc_responder_if #(
  parameter int DATA_W = 8
);
  logic              convStart;
  logic              rd_cs;
  logic [DATA_W-1:0] analog_code;
  logic              busy;
  logic [DATA_W-1:0] adcVoltage;
  logic              data_oe;
  logic              overrun;
  logic [7:0]        conv_count;

  modport master (
    output convStart, rd_cs, analog_code,
    input  busy, adcVoltage, data_oe, overrun, conv_count
  );

  modport slave (
    input  convStart, rd_cs, analog_code,
    output busy, adcVoltage, data_oe, overrun, conv_count
  );
endinterface

// File: rtl/adc_responder.sv
// Digital stand-in for the external PMIC ADC: samples a code on a convStart rising edge,
// holds busy for CONV_CYCLES clocks, then serves the result on chip-select reads.
module adc_responder #(
  parameter int DATA_W      = 8,
  parameter int CONV_CYCLES = 12
) (
  input  logic               clk,
  input  logic               reset,
  adc_responder_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} stateT;

  stateT             state, nextState;
  logic              startD;
  logic [DATA_W-1:0] sampleReg;
  logic [DATA_W-1:0] resultReg;
  logic [7:0]        cnt;

  logic startEdge;
  logic startAccept;
  logic finish;
  logic overrunSet;
  logic readEn;

  assign startEdge = bus.convStart & ~startD;

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    nextState   = state;
    startAccept = 1'b0;
    finish      = 1'b0;
    overrunSet  = 1'b0;
    readEn      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        readEn = ~bus.rd_cs;
        if (startEdge) begin
          startAccept = 1'b1;
          nextState   = CONVERT;
        end
      end
      CONVERT: begin
        // Starts and reads while converting are rejected but flagged; completion still runs.
        overrunSet = startEdge | ~bus.rd_cs;
        if (cnt == 8'd0) begin
          finish    = 1'b1;
          nextState = DONE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      startD         <= 1'b0;
      sampleReg      <= '0;
      resultReg      <= '0;
      cnt            <= 8'd0;
      bus.busy       <= 1'b0;
      bus.adcVoltage <= '0;
      bus.data_oe    <= 1'b0;
      bus.overrun    <= 1'b0;
      bus.conv_count <= 8'd0;
    end else begin
      state   <= nextState;
      startD  <= bus.convStart;

      if (startAccept) begin
        sampleReg <= bus.analog_code;
        cnt       <= 8'(CONV_CYCLES - 1);
        bus.busy  <= 1'b1;
      end else if (state == CONVERT && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end

      if (finish) begin
        resultReg      <= sampleReg;
        bus.busy       <= 1'b0;
        bus.conv_count <= bus.conv_count + 8'd1;
      end

      bus.overrun    <= bus.overrun | overrunSet;
      bus.data_oe    <= readEn;
      bus.adcVoltage <= readEn ? resultReg : '0;
    end
  end

endmodule

// File: tb/tb_adc_responder.sv
// Directed bench for adc_responder: one instance at the default conversion length and a
// second with CONV_CYCLES=1 for the back-to-back wrap sequence.
module tb_adc_responder;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  adc_responder_if #(.DATA_W(8)) ifA ();
  adc_responder_if #(.DATA_W(8)) ifB ();

  adc_responder #(.DATA_W(8), .CONV_CYCLES(12)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (ifA.slave)
  );

  adc_responder #(.DATA_W(8), .CONV_CYCLES(1)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (ifB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    ifA.convStart = 1'b0; ifA.rd_cs = 1'b1; ifA.analog_code = 8'h00;
    ifB.convStart = 1'b0; ifB.rd_cs = 1'b1; ifB.analog_code = 8'h00;
    tick();
    tick();

    check("rst_busy",    {7'd0, ifA.busy},    8'd0);
    check("rst_oe",      {7'd0, ifA.data_oe}, 8'd0);
    check("rst_data",    ifA.adcVoltage,      8'h00);
    check("rst_overrun", {7'd0, ifA.overrun}, 8'd0);
    check("rst_count",   ifA.conv_count,      8'd0);
    reset = 1'b0;

    // Basic conversion, convStart held 3 cycles -> single edge, busy for 12 cycles.
    ifA.analog_code = 8'hA5;
    ifA.convStart   = 1'b1;
    tick();
    check("t1_busy_rise", {7'd0, ifA.busy}, 8'd1);
    for (int k = 1; k < 12; k++) begin
      tick();
      if (k == 2) ifA.convStart = 1'b0;
      check("t1_busy_hold", {7'd0, ifA.busy}, 8'd1);
    end
    tick();
    check("t1_busy_fall", {7'd0, ifA.busy},    8'd0);
    check("t1_count",     ifA.conv_count,      8'd1);
    check("t1_overrun",   {7'd0, ifA.overrun}, 8'd0);

    // Two non-destructive reads in DONE separated by rd_cs high.
    ifA.rd_cs = 1'b0;
    tick();
    check("t6_rd1_oe",   {7'd0, ifA.data_oe}, 8'd1);
    check("t6_rd1_data", ifA.adcVoltage,      8'hA5);
    ifA.rd_cs = 1'b1;
    tick();
    check("t6_gap_oe",   {7'd0, ifA.data_oe}, 8'd0);
    check("t6_gap_data", ifA.adcVoltage,      8'h00);
    ifA.rd_cs = 1'b0;
    tick();
    check("t6_rd2_oe",   {7'd0, ifA.data_oe}, 8'd1);
    check("t6_rd2_data", ifA.adcVoltage,      8'hA5);
    ifA.rd_cs = 1'b1;
    tick();

    // analog_code changing after the accepted edge must not leak into the result.
    ifA.analog_code = 8'h3C;
    ifA.convStart   = 1'b1;
    tick();
    ifA.analog_code = 8'hFF;
    ifA.convStart   = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    check("t2_busy_fall", {7'd0, ifA.busy}, 8'd0);
    check("t2_count",     ifA.conv_count,   8'd2);
    ifA.rd_cs = 1'b0;
    tick();
    check("t2_oe",   {7'd0, ifA.data_oe}, 8'd1);
    check("t2_data", ifA.adcVoltage,      8'h3C);
    check("t2_overrun", {7'd0, ifA.overrun}, 8'd0);
    ifA.rd_cs = 1'b1;
    tick();

    // Second start edge 5 cycles in, plus a read during busy.
    ifA.analog_code = 8'h5A;
    ifA.convStart   = 1'b1;
    tick();
    ifA.convStart = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    ifA.convStart   = 1'b1;
    ifA.analog_code = 8'h77;
    tick();
    check("t3_overrun", {7'd0, ifA.overrun}, 8'd1);
    check("t3_busy5",   {7'd0, ifA.busy},    8'd1);
    ifA.convStart = 1'b0;
    ifA.rd_cs     = 1'b0;
    tick();
    check("t3_busy_rd_oe",   {7'd0, ifA.data_oe}, 8'd0);
    check("t3_busy_rd_data", ifA.adcVoltage,      8'h00);
    ifA.rd_cs = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("t3_busy11", {7'd0, ifA.busy}, 8'd1);
    tick();
    check("t3_busy_fall", {7'd0, ifA.busy},    8'd0);
    check("t3_count",     ifA.conv_count,      8'd3);
    ifA.rd_cs = 1'b0;
    tick();
    check("t3_data",        ifA.adcVoltage,      8'h5A);
    check("t3_overrun_stk", {7'd0, ifA.overrun}, 8'd1);
    ifA.rd_cs = 1'b1;
    tick();

    // Reset in the middle of a conversion discards it.
    ifA.analog_code = 8'h11;
    ifA.convStart   = 1'b1;
    tick();
    ifA.convStart = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_busy",    {7'd0, ifA.busy},    8'd0);
    check("t4_count",   ifA.conv_count,      8'd0);
    check("t4_overrun", {7'd0, ifA.overrun}, 8'd0);
    ifA.rd_cs = 1'b0;
    tick();
    check("t4_rd_oe",   {7'd0, ifA.data_oe}, 8'd1);
    check("t4_rd_data", ifA.adcVoltage,      8'h00);
    ifA.rd_cs = 1'b1;
    tick();
    check("t4_busy_idle", {7'd0, ifA.busy}, 8'd0);

    // 256 back-to-back single-cycle conversions on the CONV_CYCLES=1 instance.
    for (int i = 0; i < 256; i++) begin
      ifB.analog_code = (i == 255) ? 8'h81 : 8'(i);
      ifB.convStart   = 1'b1;
      tick();
      check("t5_busy_hi", {7'd0, ifB.busy}, 8'd1);
      ifB.convStart = 1'b0;
      tick();
      check("t5_busy_lo", {7'd0, ifB.busy}, 8'd0);
      if (i == 254) check("t5_count255", ifB.conv_count, 8'd255);
    end
    check("t5_count_wrap", ifB.conv_count,      8'd0);
    check("t5_overrun",    {7'd0, ifB.overrun}, 8'd0);
    ifB.rd_cs = 1'b0;
    tick();
    check("t5_rd_oe",   {7'd0, ifB.data_oe}, 8'd1);
    check("t5_rd_data", ifB.adcVoltage,      8'h81);
    ifB.rd_cs = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
